// File: rtl/mips_cpu_pkg.sv
// Shared MIPS-style CPU definitions: branch-select encodings, NOP word,
// default halt opcode and the fetch FSM state type.
package mips_cpu_pkg;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JUMP = 2'b10;
    localparam logic [1:0] BS_REG  = 2'b11;

    localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
    localparam logic [6:0]  HALT_OPCODE_DEF = 7'h7F;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_pc_select.sv
// Branch resolution for the fetch stage: decides whether the instruction in
// execute redirects fetch, and where to.
module pc_select
    import mips_cpu_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic [1:0]           bs_exe,
    input  logic                 ps_exe,
    input  logic                 z_exe,
    input  logic [DATA_BITS-1:0] bra,
    input  logic [DATA_BITS-1:0] raa,
    output logic                 taken,
    output logic [DATA_BITS-1:0] target
);

    always_comb begin
        taken  = 1'b0;
        target = bra;
        unique case (bs_exe)
            BS_COND: taken = ps_exe ? ~z_exe : z_exe;
            BS_JUMP: taken = 1'b1;
            BS_REG: begin
                taken  = 1'b1;
                target = raa;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with halt detection and branch redirect.
// Optional IF_STALL_EN macro adds a stall input that freezes the stage.
module instruction_fetch
    import mips_cpu_pkg::*;
#(
    parameter int                    INSTRUCTION_BITS = 32,
    parameter int                    DATA_BITS        = 32,
    parameter logic [DATA_BITS-1:0]  PC_RESET         = '0,
    parameter logic [6:0]            HALT_OPCODE      = HALT_OPCODE_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef IF_STALL_EN
    input  logic                        stall,
`endif
    input  logic [1:0]                  BS_EXE,
    input  logic                        PS_EXE,
    input  logic                        Z_EXE,
    input  logic [DATA_BITS-1:0]        BrA,
    input  logic [DATA_BITS-1:0]        RAA,
    input  logic [INSTRUCTION_BITS-1:0] imem_data,
    output logic [DATA_BITS-1:0]        imem_addr,
    output logic [INSTRUCTION_BITS-1:0] instruction,
    output logic [DATA_BITS-1:0]        pc_min_one,
    output logic                        flush
);

    localparam logic [INSTRUCTION_BITS-1:0] NOP = INSTRUCTION_BITS'(NOP_WORD);

    fetch_state_t                state, state_next;
    logic [DATA_BITS-1:0]        pc, pc_next, pc_inc;
    logic [INSTRUCTION_BITS-1:0] instr_next;
    logic [DATA_BITS-1:0]        pcm_next;
    logic                        taken, hold, is_halt;
    logic [DATA_BITS-1:0]        target;

    pc_select #(.DATA_BITS(DATA_BITS)) u_pc_select (
        .bs_exe (BS_EXE),
        .ps_exe (PS_EXE),
        .z_exe  (Z_EXE),
        .bra    (BrA),
        .raa    (RAA),
        .taken  (taken),
        .target (target)
    );

`ifdef IF_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign imem_addr = pc;
    assign flush     = ~taken;
    assign pc_inc    = pc + DATA_BITS'(1);
    assign is_halt   = imem_data[INSTRUCTION_BITS-1 -: 7] == HALT_OPCODE;

    // Redirect wins over stall and halt; a halted stage only emits bubbles.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instruction;
        pcm_next   = pc_min_one;
        if (taken) begin
            state_next = RUN;
            pc_next    = target;
            instr_next = NOP;
            pcm_next   = target;
        end else if (hold) begin
            state_next = state;
        end else if (state == RUN) begin
            instr_next = imem_data;
            pcm_next   = pc_inc;
            if (is_halt) state_next = HALT;
            else         pc_next    = pc_inc;
        end else begin
            instr_next = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= PC_RESET;
            instruction <= NOP;
            pc_min_one  <= PC_RESET;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instr_next;
            pc_min_one  <= pcm_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch against a
// behavioural fetch model; builds with or without IF_STALL_EN.
module tb_instruction_fetch;

`ifdef IF_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  BS_EXE = 2'b00;
    logic        PS_EXE = 1'b0;
    logic        Z_EXE = 1'b0;
    logic [31:0] BrA = '0;
    logic [31:0] RAA = '0;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic [31:0] pc_min_one;
    logic        flush;

    logic [31:0] mem [256];

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_pc, m_instr, m_pcm;
    bit          m_halt;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
`ifdef IF_STALL_EN
        .stall       (stall),
`endif
        .BS_EXE      (BS_EXE),
        .PS_EXE      (PS_EXE),
        .Z_EXE       (Z_EXE),
        .BrA         (BrA),
        .RAA         (RAA),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .instruction (instruction),
        .pc_min_one  (pc_min_one),
        .flush       (flush)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; entered and left on a falling edge.
    task automatic step(input bit rst, input logic [1:0] bs, input bit ps,
                        input bit z, input logic [31:0] bra,
                        input logic [31:0] raa, input bit stl);
        bit          tk;
        logic [31:0] word;
        reset  = rst;
        BS_EXE = bs;
        PS_EXE = ps;
        Z_EXE  = z;
        BrA    = bra;
        RAA    = raa;
        stall  = stl;
        #1;
        case (bs)
            2'd1:    tk = ps ? !z : z;
            2'd2,
            2'd3:    tk = 1;
            default: tk = 0;
        endcase
        check("flush", {31'b0, flush}, {31'b0, !tk});
        check("addr_pre", imem_addr, m_pc);
        word = mem[m_pc[7:0]];
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pcm = 0; m_halt = 0;
        end else if (tk) begin
            m_pc    = (bs == 2'd3) ? raa : bra;
            m_pcm   = m_pc;
            m_instr = 0;
            m_halt  = 0;
        end else if (STALL_EN && stl) begin
            m_halt = m_halt;
        end else if (!m_halt) begin
            m_instr = word;
            m_pcm   = m_pc + 1;
            if (word[31:25] == 7'h7F) m_halt = 1;
            else                      m_pc   = m_pc + 1;
        end else begin
            m_instr = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("instruction", instruction, m_instr);
        check("pc_min_one", pc_min_one, m_pcm);
        check("imem_addr", imem_addr, m_pc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pcm = 0; m_halt = 0;
        for (int k = 0; k < 256; k++) mem[k] = k + 1;
        mem[8'h10] = {7'h7F, 25'h0012345};
        @(negedge clk);

        // reset with a redirect asserted: reset must still win
        step(1, 2'b10, 0, 0, 32'h55, 0, 0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", imem_addr, 32'h0);
        idle(3);
        check("seq3_instr", instruction, 32'd3);
        check("seq3_pcm", pc_min_one, 32'd3);
        check("seq3_pc", imem_addr, 32'd3);
        idle(2);
        check("pc5", imem_addr, 32'd5);

        step(0, 2'b01, 0, 1, 32'h40, 0, 0);
        check("beq_pc", imem_addr, 32'h40);
        check("beq_instr", instruction, 32'h0);
        check("beq_pcm", pc_min_one, 32'h40);
        step(0, 2'b01, 0, 0, 32'h99, 0, 0);
        check("bnt_pc", imem_addr, 32'h41);
        step(0, 2'b11, 0, 0, 32'h99, 32'h80, 0);
        check("jr_pc", imem_addr, 32'h80);

        step(0, 2'b10, 0, 0, 32'h10, 0, 0);
        idle(3);
        check("halt_pc", imem_addr, 32'h10);
        check("halt_instr", instruction, 32'h0);
        step(0, 2'b10, 0, 0, 32'h20, 0, 0);
        check("unhalt_pc", imem_addr, 32'h20);
        idle(1);
        check("unhalt_run", imem_addr, 32'h21);

        step(0, 2'b10, 0, 0, 32'hFFFF_FFFF, 0, 0);
        idle(1);
        check("wrap_pc", imem_addr, 32'h0);
        check("wrap_pcm", pc_min_one, 32'h0);

        if (STALL_EN) begin
            idle(2);
            step(0, 2'b00, 0, 0, 0, 0, 1);
            step(0, 2'b00, 0, 0, 0, 0, 1);
            check("stall_pc", imem_addr, 32'd2);
            step(0, 2'b10, 0, 0, 32'h8, 0, 1);
            check("stall_br_pc", imem_addr, 32'h8);
            check("stall_br_instr", instruction, 32'h0);
        end

        for (int k = 0; k < 256; k++) begin
            mem[k] = $urandom;
            if ($urandom_range(0, 7) == 0) mem[k][31:25] = 7'h7F;
            else if (mem[k][31:25] == 7'h7F) mem[k][25] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            logic [1:0] bs;
            bs = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            step($urandom_range(0, 49) == 0, bs, 1'($urandom), 1'($urandom),
                 $urandom, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter INSTRUCTION_BITS, default 32: instruction word width.
REQ-002 Parameter DATA_BITS, default 32: PC and address width.
REQ-003 Parameter PC_RESET, default 0: PC value loaded on reset.
REQ-004 Parameter HALT_OPCODE, default 7'h7F: opcode (instruction[31:25]) that stops sequential fetch.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 BS_EXE  input  2  branch select of the instruction in execute.
REQ-008 PS_EXE  input  1  branch polarity of the instruction in execute.
REQ-009 Z_EXE  input  1  zero flag from the execute ALU.
REQ-010 BrA  input  DATA_BITS  branch/jump target from execute.
REQ-011 RAA  input  DATA_BITS  register jump address from execute.
REQ-012 imem_data  input  INSTRUCTION_BITS  combinational instruction-memory read data for imem_addr.
REQ-013 imem_addr  output  DATA_BITS  current PC, driven combinationally from the PC register.
REQ-014 instruction  output  INSTRUCTION_BITS  registered instruction to the decode/operand-fetch stage.
REQ-015 pc_min_one  output  DATA_BITS  registered PC+1 of that instruction.
REQ-016 flush  output  1  active-low squash for the decode/operand-fetch stage; 0 = kill.

Function
REQ-017 taken SHALL be (BS_EXE==2'b01 & (PS_EXE ? ~Z_EXE : Z_EXE)) | BS_EXE==2'b10 | BS_EXE==2'b11.
REQ-018 Target SHALL be BrA for BS_EXE 01/10, RAA for 11.
REQ-019 flush SHALL equal ~taken, combinational, same cycle.
REQ-020 FSM states RUN, HALT; reset state RUN.
REQ-021 RUN, not taken: PC<=PC+1 (mod 2^DATA_BITS), instruction<=imem_data, pc_min_one<=PC+1.
REQ-022 Any state, taken: PC<=target, instruction<=NOP (all zeros), pc_min_one<=target, state<=RUN; taken has priority over all other events.
REQ-023 RUN, not taken, imem_data[31:25]==HALT_OPCODE: instruction<=imem_data, pc_min_one<=PC+1, PC unchanged, state<=HALT.
REQ-024 HALT, not taken: PC, pc_min_one unchanged; instruction<=NOP.
REQ-025 PC at all-ones SHALL wrap to zero on increment; pc_min_one likewise.

Reset
REQ-026 On reset: PC=PC_RESET, instruction=NOP, pc_min_one=PC_RESET, state=RUN; reset overrides taken and stall.
REQ-027 flush is combinational and unaffected by reset.

Configuration
REQ-028 Macro IF_STALL_EN SHALL add input stall (1 bit, active-high).
REQ-029 With IF_STALL_EN, stall=1 and not taken: PC, instruction, pc_min_one, state held; taken while stalled executes REQ-022.
REQ-030 Without IF_STALL_EN: no stall port; fetch advances every cycle per REQ-021..024.

Structure
REQ-031 Shared package mips_cpu_pkg SHALL hold BS encodings, NOP word, HALT_OPCODE default, state enum.
REQ-032 Sub-module pc_select SHALL contain REQ-017/018 combinational taken/target logic.

Verification
REQ-033 Reset with PC_RESET=0, imem returns k+1 at address k -> after 3 cycles instruction=3, pc_min_one=3, imem_addr=3.
REQ-034 PC=5, BS_EXE=01, PS_EXE=0, Z_EXE=1, BrA=0x40 -> flush=0 that cycle; next: imem_addr=0x40, instruction=0, pc_min_one=0x40.
REQ-035 BS_EXE=01, PS_EXE=0, Z_EXE=0 -> flush=1, PC increments; BS_EXE=11, RAA=0x80 -> next PC=0x80.
REQ-036 imem at 0x10 holds opcode 7'h7F -> PC frozen at 0x10, subsequent instruction=0; then BS_EXE=10, BrA=0x20 -> RUN, PC=0x20.
REQ-037 PC=0xFFFFFFFF, no branch -> next PC=0, pc_min_one=0.
REQ-038 IF_STALL_EN: stall=1 for 2 cycles -> outputs held; stall=1 with BS_EXE=10, BrA=0x8 -> PC=0x8, instruction=0.
